// File: rtl/jk_bank_arbiter.sv
// rtl/jk_bank_arbiter.sv - round-robin arbiter sequencing JK ops onto a shared flip-flop bank
// Optional feature macro: JK_ARB_ERR_EN adds err_o, flagging out-of-range bit indices.
module jk_bank_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDXW  = 3
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NREQ-1:0]        req_i,
  input  logic [2*NREQ-1:0]      op_i,
  input  logic [IDXW*NREQ-1:0]   idx_i,
  output logic [NREQ-1:0]        gnt_o,
  output logic                   done_o,
  output logic                   busy_o,
  output logic [WIDTH-1:0]       q_o,
  output logic [WIDTH-1:0]       qbar_o
`ifdef JK_ARB_ERR_EN
  ,
  output logic                   err_o
`endif
);

  localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int SW   = PTRW + 1;

  typedef enum logic [1:0] {IDLE, APPLY, ACK} state_e;

  state_e            state_q, state_d;
  logic [PTRW-1:0]   ptr_q, ptr_d, win_q, win_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [1:0]        op_q, op_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]  q_q, q_d;

  logic              found;
  logic [PTRW-1:0]   pick;
  logic [1:0]        op_sel;
  logic [IDXW-1:0]   idx_sel;
  logic              in_range;

  // Search starts at ptr and wraps, so the first hit is the round-robin winner.
  always_comb begin : rr_search
    logic [SW-1:0]   sum;
    logic [PTRW-1:0] cand;
    found = 1'b0;
    pick  = ptr_q;
    sum   = '0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr_q} + SW'(k);
      if (sum >= SW'(NREQ)) sum = sum - SW'(NREQ);
      cand = sum[PTRW-1:0];
      if (!found && req_i[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    op_sel  = '0;
    idx_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick == PTRW'(i)) begin
        op_sel  = op_i[2*i +: 2];
        idx_sel = idx_i[IDXW*i +: IDXW];
      end
    end
  end

  assign in_range = (32'(idx_q) < WIDTH);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    gnt_d   = gnt_q;
    op_d    = op_q;
    idx_d   = idx_q;
    q_d     = q_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          win_d   = pick;
          gnt_d   = NREQ'(1) << pick;
          op_d    = op_sel;
          idx_d   = idx_sel;
          state_d = APPLY;
        end else begin
          gnt_d = '0;
        end
      end
      APPLY: begin
        // Out-of-range indices are dropped; the handshake still completes.
        if (in_range) begin
          case (op_q)
            2'b01:   q_d[idx_q] = 1'b0;
            2'b10:   q_d[idx_q] = 1'b1;
            2'b11:   q_d[idx_q] = ~q_q[idx_q];
            default: q_d[idx_q] = q_q[idx_q];
          endcase
        end
        state_d = ACK;
      end
      ACK: begin
        gnt_d   = '0;
        ptr_d   = (win_q == PTRW'(NREQ - 1)) ? '0 : win_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      gnt_q   <= '0;
      op_q    <= '0;
      idx_q   <= '0;
      q_q     <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      gnt_q   <= gnt_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      q_q     <= q_d;
    end
  end

  assign gnt_o  = gnt_q;
  assign done_o = (state_q == ACK);
  assign busy_o = (state_q != IDLE);
  assign q_o    = q_q;
  assign qbar_o = ~q_q;
`ifdef JK_ARB_ERR_EN
  assign err_o  = (state_q == ACK) && !in_range;
`endif

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// tb/tb_jk_bank_arbiter.sv - self-checking bench for jk_bank_arbiter (directed plus randomized ops)
// Builds with WIDTH=6 when JK_ARB_ERR_EN is defined so out-of-range indices are reachable.
module tb_jk_bank_arbiter;

  localparam int NREQ = 4;
  localparam int IDXW = 3;
`ifdef JK_ARB_ERR_EN
  localparam int WIDTH = 6;
`else
  localparam int WIDTH = 8;
`endif

  logic                 clk;
  logic                 rst_n;
  logic [NREQ-1:0]      req;
  logic [2*NREQ-1:0]    op;
  logic [IDXW*NREQ-1:0] idx;
  logic [NREQ-1:0]      gnt;
  logic                 done;
  logic                 busy;
  logic [WIDTH-1:0]     q;
  logic [WIDTH-1:0]     qbar;
`ifdef JK_ARB_ERR_EN
  logic                 err;
`endif

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] model_q;
  int               model_ptr;

  jk_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDXW(IDXW)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .req_i  (req),
    .op_i   (op),
    .idx_i  (idx),
    .gnt_o  (gnt),
    .done_o (done),
    .busy_o (busy),
    .q_o    (q),
    .qbar_o (qbar)
`ifdef JK_ARB_ERR_EN
    ,
    .err_o  (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic drive(input int r, input logic [1:0] o, input logic [IDXW-1:0] ix);
    req[r] = 1'b1;
    op[2*r +: 2] = o;
    idx[IDXW*r +: IDXW] = ix;
  endtask

  // Called at the falling edge of an IDLE cycle; runs one full handshake against the model.
  task automatic txn();
    int w;
    int o;
    int ix;
    logic [WIDTH-1:0] nq;
    logic [WIDTH-1:0] nb;
    logic [WIDTH-1:0] ob;
    w = -1;
    for (int k = 0; k < NREQ; k++) begin
      if (w < 0 && req[(model_ptr + k) % NREQ]) w = (model_ptr + k) % NREQ;
    end
    ob = ~model_q;
    if (w < 0) begin
      @(negedge clk);
      check("idle_gnt", 32'(gnt), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_done", 32'(done), 32'd0);
      check("idle_q", 32'(q), 32'(model_q));
      return;
    end
    o  = int'(op[2*w +: 2]);
    ix = int'(idx[IDXW*w +: IDXW]);
    nq = model_q;
    if (ix < WIDTH) begin
      if (o == 1) nq[ix] = 1'b0;
      else if (o == 2) nq[ix] = 1'b1;
      else if (o == 3) nq[ix] = ~nq[ix];
    end
    nb = ~nq;
    @(negedge clk);
    check("apply_gnt", 32'(gnt), 32'(1) << w);
    check("apply_busy", 32'(busy), 32'd1);
    check("apply_done", 32'(done), 32'd0);
    check("apply_q", 32'(q), 32'(model_q));
    check("apply_qbar", 32'(qbar), 32'(ob));
`ifdef JK_ARB_ERR_EN
    check("apply_err", 32'(err), 32'd0);
`endif
    @(negedge clk);
    check("ack_gnt", 32'(gnt), 32'(1) << w);
    check("ack_busy", 32'(busy), 32'd1);
    check("ack_done", 32'(done), 32'd1);
    check("ack_q", 32'(q), 32'(nq));
    check("ack_qbar", 32'(qbar), 32'(nb));
`ifdef JK_ARB_ERR_EN
    check("ack_err", 32'(err), (ix >= WIDTH) ? 32'd1 : 32'd0);
`endif
    req[w]    = 1'b0;
    model_q   = nq;
    model_ptr = (w + 1) % NREQ;
    @(negedge clk);
    check("post_gnt", 32'(gnt), 32'd0);
    check("post_done", 32'(done), 32'd0);
    check("post_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    req       = NREQ'($urandom);
    op        = 8'($urandom);
    idx       = 12'($urandom);
    model_q   = '0;
    model_ptr = 0;
    repeat (3) @(negedge clk);
    check("rst_q", 32'(q), 32'd0);
    check("rst_qbar", 32'(qbar), 32'((1 << WIDTH) - 1));
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
`ifdef JK_ARB_ERR_EN
    check("rst_err", 32'(err), 32'd0);
`endif
    req   = '0;
    rst_n = 1'b1;
    @(negedge clk);

    drive(0, 2'b10, 3'd3); txn();
    check("single_set_q", 32'(q), 32'h08);
    drive(2, 2'b11, 3'd0); txn();
    check("toggle1_q", 32'(q), 32'h09);
    drive(2, 2'b11, 3'd0); txn();
    check("toggle2_q", 32'(q), 32'h08);
    drive(2, 2'b01, 3'd3); txn();
    check("reset_op_q", 32'(q), 32'h00);

    drive(0, 2'b10, 3'd1); txn();
    drive(0, 2'b10, 3'd5);
    @(negedge clk);
    check("midop_busy_pre", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midop_q", 32'(q), 32'd0);
    check("midop_gnt", 32'(gnt), 32'd0);
    check("midop_done", 32'(done), 32'd0);
    check("midop_busy", 32'(busy), 32'd0);
    req       = '0;
    model_q   = '0;
    model_ptr = 0;
    @(negedge clk);
    check("midop_done_held", 32'(done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("midop_idle", 32'(busy), 32'd0);

    for (int r = 0; r < NREQ; r++) drive(r, 2'b10, IDXW'(r));
    check("cont_first_ptr", 32'(model_ptr), 32'd0);
    repeat (NREQ) txn();
    check("cont_final_q", 32'(q), 32'h0F);

    drive(1, 2'b10, 3'd7); txn();

    repeat (60) begin
      req = NREQ'($urandom_range(0, 15));
      op  = 8'($urandom);
      idx = 12'($urandom);
      txn();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
